// File: rtl/apt_match_collector_if.sv
// Bus bundle for apt_match_collector: address stream in, APT SRAM read port, match vector out.
// With MATCH_PRIO_ENC_EN defined the bundle also carries out_hit/out_idx.
interface apt_match_collector_if #(
   parameter int W = 16,
   parameter int D = 64
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_apta;
   logic         mem_rd_en;
   logic [W-1:0] mem_addr;
   logic [D-1:0] mem_rdata;
   logic         out_valid;
   logic         out_ready;
   logic [D-1:0] out_match;
`ifdef MATCH_PRIO_ENC_EN
   logic                 out_hit;
   logic [$clog2(D)-1:0] out_idx;

   modport master (
      output in_valid, in_apta, mem_rdata, out_ready,
      input  in_ready, mem_rd_en, mem_addr, out_valid, out_match, out_hit, out_idx
   );
   modport slave (
      input  in_valid, in_apta, mem_rdata, out_ready,
      output in_ready, mem_rd_en, mem_addr, out_valid, out_match, out_hit, out_idx
   );
`else
   modport master (
      output in_valid, in_apta, mem_rdata, out_ready,
      input  in_ready, mem_rd_en, mem_addr, out_valid, out_match
   );
   modport slave (
      input  in_valid, in_apta, mem_rdata, out_ready,
      output in_ready, mem_rd_en, mem_addr, out_valid, out_match
   );
`endif
endinterface

// File: rtl/apt_match_collector.sv
// Collects N_SW APT addresses per search, reads the APT SRAM and ANDs the rule vectors into one match vector.
// Optional MATCH_PRIO_ENC_EN adds out_hit / out_idx (lowest set bit) registered alongside out_match.
module apt_match_collector #(
   parameter int w    = 16,
   parameter int N_SW = 4,
   parameter int D    = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   apt_match_collector_if.slave    bus
);
   localparam int CNT_W = (N_SW > 1) ? $clog2(N_SW) : 1;
   localparam logic [CNT_W-1:0] LAST_SW = CNT_W'(N_SW - 1);

   typedef enum logic [1:0] {ACC, WAIT, OUT} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] sw_cnt_reg;
   logic [D-1:0]     acc_reg;
   logic             acc_zero_reg;
   logic             rd_pend_reg;
   logic [D-1:0]     out_match_reg;

   logic         in_ready_c;
   logic         out_valid_c;
   logic         accept;
   logic         rd_en;
   logic [D-1:0] acc_and;
   logic [D-1:0] acc_fold;

   assign accept   = bus.in_valid & in_ready_c;
   // Once the partial AND is zero the result is known; skip the remaining SRAM reads.
   assign rd_en    = accept & ~acc_zero_reg;
   assign acc_and  = acc_reg & bus.mem_rdata;
   assign acc_fold = rd_pend_reg ? acc_and : acc_reg;

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.mem_rd_en = rd_en;
   assign bus.mem_addr  = w'(bus.in_apta);
   assign bus.out_match = out_match_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ACC;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_reg)
         ACC: begin
            in_ready_c = 1'b1;
            if (bus.in_valid && sw_cnt_reg == LAST_SW) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            state_next = OUT;
         end
         OUT: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_next = ACC;
            end
         end
         default: begin
            state_next = ACC;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_cnt_reg    <= '0;
         acc_reg       <= '1;
         acc_zero_reg  <= 1'b0;
         rd_pend_reg   <= 1'b0;
         out_match_reg <= '0;
      end else begin
         rd_pend_reg <= rd_en;
         if (accept) begin
            sw_cnt_reg <= (sw_cnt_reg == LAST_SW) ? '0 : sw_cnt_reg + CNT_W'(1);
         end
         if (state_reg == OUT && bus.out_ready) begin
            acc_reg      <= '1;
            acc_zero_reg <= 1'b0;
         end else if (rd_pend_reg) begin
            acc_reg      <= acc_and;
            acc_zero_reg <= (acc_and == '0);
         end
         // The last read lands during WAIT, so fold it in directly when capturing the result.
         if (state_reg == WAIT) begin
            out_match_reg <= acc_fold;
         end
      end
   end

`ifdef MATCH_PRIO_ENC_EN
   localparam int IDX_W = $clog2(D);

   logic             hit_next;
   logic [IDX_W-1:0] idx_next;
   logic             out_hit_reg;
   logic [IDX_W-1:0] out_idx_reg;

   always_comb begin
      hit_next = |acc_fold;
      idx_next = '0;
      for (int i = D - 1; i >= 0; i--) begin
         if (acc_fold[i]) begin
            idx_next = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_hit_reg <= 1'b0;
         out_idx_reg <= '0;
      end else if (state_reg == WAIT) begin
         out_hit_reg <= hit_next;
         out_idx_reg <= idx_next;
      end
   end

   assign bus.out_hit = out_hit_reg;
   assign bus.out_idx = out_idx_reg;
`endif
endmodule
